// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter
//   Shares one SDRAM FIFO port (write/read load-request-buffer interface)
//   among NREQ VRAM clients. Grants round-robin, runs one transaction at a
//   time, sequences the FIFO strobes and returns read words to the owner.
//
// Ports
//   clk, reset            clock, asynchronous active-high reset
//   i_req_valid/write     per-requester request and direction (1 = write)
//   i_req_addr/wdata/len  per-requester descriptor (len 0 -> 1, clamp MAX_BURST)
//   o_req_ack             one-cycle pulse when a descriptor is latched
//   o_done / o_err        one-cycle completion / timeout-abort pulse
//   o_rd_valid, o_rd_data read word valid (owner bit) and shared read data
//   o_write_ld/_req, o_writeaddr/_data, i_wr_buffer   write FIFO side
//   o_read_ld/_req, o_readaddr, i_rd_buffer, i_readdata read FIFO side
module vram_port_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 4096
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       i_req_valid,
    input  logic [NREQ-1:0]       i_req_write,
    input  logic [NREQ-1:0][24:0] i_req_addr,
    input  logic [NREQ-1:0][15:0] i_req_wdata,
    input  logic [NREQ-1:0][4:0]  i_req_len,
    output logic [NREQ-1:0]       o_req_ack,
    output logic [NREQ-1:0]       o_done,
    output logic [NREQ-1:0]       o_err,
    output logic [NREQ-1:0]       o_rd_valid,
    output logic [15:0]           o_rd_data,
    output logic                  o_write_ld,
    output logic                  o_write_req,
    output logic [24:0]           o_writeaddr,
    output logic [15:0]           o_writedata,
    input  logic [15:0]           i_wr_buffer,
    output logic                  o_read_ld,
    output logic                  o_read_req,
    output logic [24:0]           o_readaddr,
    input  logic [15:0]           i_rd_buffer,
    input  logic [15:0]           i_readdata
);

    typedef enum logic [3:0] {
        S_IDLE, S_W_LD, S_W_REQ, S_W_SET, S_W_DRN,
        S_R_GAP, S_R_LD, S_R_FILL, S_R_STR, S_R_TAIL, S_FIN
    } state_t;

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // One counter serves the settle/gap delays, the burst beat count and the
    // FIFO wait timeout, so size it for the largest of those.
    localparam int CW = $clog2(((TIMEOUT > 32) ? TIMEOUT : 32) + 1);
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

    state_t          r_state;
    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   r_owner;
    logic [CW-1:0]   r_cnt;
    logic [4:0]      r_len_e;
    logic [24:0]     r_addr;
    logic [15:0]     r_wdata;
    logic [NREQ-1:0] r_req_ack, r_done, r_err, r_rd_valid;
    logic [15:0]     r_rd_data;
    logic            r_write_ld, r_write_req, r_read_ld, r_read_req;
    logic [24:0]     r_writeaddr, r_readaddr;
    logic [15:0]     r_writedata;

    logic            w_any;
    logic [PW-1:0]   w_pick;
    logic [NREQ-1:0] w_own_oh;
    logic [NREQ-1:0] w_pick_oh;

    function automatic logic [4:0] eff_len(input logic [4:0] len);
        if (len == 5'd0) return 5'd1;
        if (int'(len) > MAX_BURST) return 5'(MAX_BURST);
        return len;
    endfunction

    // Round-robin scan: walk from the far end back toward ptr so the
    // requester nearest to ptr is the last (winning) assignment.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_pick = '0;
        idx    = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = (int'(r_ptr) + k) % NREQ;
            if (i_req_valid[PW'(idx)]) begin
                w_any  = 1'b1;
                w_pick = PW'(idx);
            end
        end
    end

    assign w_own_oh  = NREQ'(1) << r_owner;
    assign w_pick_oh = NREQ'(1) << w_pick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_cnt       <= '0;
            r_len_e     <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_req_ack   <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_rd_valid  <= '0;
            r_rd_data   <= '0;
            r_write_ld  <= 1'b0;
            r_write_req <= 1'b0;
            r_read_ld   <= 1'b0;
            r_read_req  <= 1'b0;
            r_writeaddr <= '0;
            r_writedata <= '0;
            r_readaddr  <= '0;
        end else begin
            // Strobes and pulses default low; each state raises what it needs.
            r_req_ack   <= '0;
            r_done      <= '0;
            r_err       <= '0;
            r_write_ld  <= 1'b0;
            r_write_req <= 1'b0;
            r_read_ld   <= 1'b0;
            r_read_req  <= 1'b0;
            // FIFO data lags read_req by one cycle, so valid follows the strobe.
            r_rd_valid  <= r_read_req ? w_own_oh : '0;
            r_rd_data   <= i_readdata;

            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_owner   <= w_pick;
                        r_addr    <= i_req_addr[w_pick];
                        r_wdata   <= i_req_wdata[w_pick];
                        r_len_e   <= eff_len(i_req_len[w_pick]);
                        r_req_ack <= w_pick_oh;
                        r_ptr     <= (w_pick == PW'(NREQ - 1)) ? '0 : w_pick + 1'b1;
                        r_cnt     <= '0;
                        if (i_req_write[w_pick]) begin
                            r_state     <= S_W_LD;
                            r_write_ld  <= 1'b1;
                            r_writeaddr <= i_req_addr[w_pick];
                        end else begin
                            r_state <= S_R_GAP;
                        end
                    end
                end
                S_W_LD: begin
                    r_state     <= S_W_REQ;
                    r_write_req <= 1'b1;
                    r_writedata <= r_wdata;
                end
                S_W_REQ: begin
                    r_state <= S_W_SET;
                    r_cnt   <= '0;
                end
                S_W_SET: begin
                    if (r_cnt == CW'(2)) begin
                        r_state <= S_W_DRN;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_W_DRN: begin
                    if (i_wr_buffer == 16'd0) begin
                        r_state <= S_FIN;
                        r_done  <= w_own_oh;
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= S_IDLE;
                        r_err   <= w_own_oh;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_R_GAP: begin
                    if (r_cnt == CW'(4)) begin
                        r_state    <= S_R_LD;
                        r_read_ld  <= 1'b1;
                        r_readaddr <= r_addr;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_R_LD: begin
                    r_state <= S_R_FILL;
                    r_cnt   <= '0;
                end
                S_R_FILL: begin
                    if (i_rd_buffer >= 16'(r_len_e)) begin
                        r_state    <= S_R_STR;
                        r_read_req <= 1'b1;
                        r_cnt      <= '0;
                    end else if (r_cnt == TO_LAST) begin
                        r_state <= S_IDLE;
                        r_err   <= w_own_oh;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_R_STR: begin
                    // Counts read_req beats already issued; stop after len_e.
                    if (r_cnt == CW'(r_len_e - 5'd1)) begin
                        r_state <= S_R_TAIL;
                    end else begin
                        r_read_req <= 1'b1;
                        r_cnt      <= r_cnt + 1'b1;
                    end
                end
                S_R_TAIL: begin
                    r_state <= S_FIN;
                    r_done  <= w_own_oh;
                end
                S_FIN:   r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_req_ack   = r_req_ack;
    assign o_done      = r_done;
    assign o_err       = r_err;
    assign o_rd_valid  = r_rd_valid;
    assign o_rd_data   = r_rd_data;
    assign o_write_ld  = r_write_ld;
    assign o_write_req = r_write_req;
    assign o_writeaddr = r_writeaddr;
    assign o_writedata = r_writedata;
    assign o_read_ld   = r_read_ld;
    assign o_read_req  = r_read_req;
    assign o_readaddr  = r_readaddr;

endmodule

// File: doc/vram_port_arbiter.md
# vram_port_arbiter

Shares the single SDRAM FIFO port (write/read load-request-buffer interface) among up to four VRAM clients: playfield init, falling-piece erase/draw, row readback, and line-clear copy. It accepts one transaction descriptor at a time, grants requesters round-robin, and sequences the FIFO handshakes: load pulse, request pulse(s), settle, then drain or fill wait. It routes burst read data back to the owning requester. It sits between the game-logic write/read engines and the SDRAM controller FIFOs.

## Interface
Parameters:
- NREQ, 4, number of requesters (2..4)
- MAX_BURST, 16, maximum read burst length in words
- TIMEOUT, 4096, cycles allowed in any FIFO wait state before abort

Ports:
- Clock and reset: reset, asynchronous, active-high; clock clk.
- req_valid  in  NREQ  per-requester request; held until req_ack
- req_write  in  NREQ  1 = single-word write, 0 = burst read
- req_addr  in  NREQ×25  word address
- req_wdata  in  NREQ×16  write data
- req_len  in  NREQ×5  read length; 0 is treated as 1, values above MAX_BURST are clamped to MAX_BURST
- req_ack  out  NREQ  one-cycle pulse when the descriptor is latched
- done  out  NREQ  one-cycle pulse when the transaction completes
- err  out  NREQ  one-cycle pulse on timeout abort (given instead of done)
- rd_valid  out  NREQ  read word valid for the owning requester
- rd_data  out  16  read word, shared by all requesters
- write_ld, write_req  out  1  write FIFO load and request strobes
- writeaddr  out  25; writedata  out  16
- wr_buffer  in  16  write FIFO occupancy
- read_ld, read_req  out  1  read FIFO load and request strobes
- readaddr  out  25
- rd_buffer  in  16  read FIFO occupancy
- readdata  in  16  read FIFO data

## Operation
- Reset values:
  - All outputs are 0.
  - State is IDLE.
  - Round-robin pointer is 0.
  - Wait counters are 0.
- Arbitration (IDLE only):
  - Scan requesters starting at ptr and pick the first one with req_valid set.
  - Latch its write flag, address, data and effective length (len_e).
  - Pulse req_ack[owner] and set ptr = owner+1 mod NREQ.
  - Next state is W_LD for a write, R_GAP for a read.
- Write path:
  - W_LD: write_ld=1, writeaddr=addr.
  - W_REQ: write_ld=0, write_req=1, writedata=wdata.
  - W_SET: write_req=0; hold 3 cycles.
  - W_DRN: wait for wr_buffer==0.
  - FIN: pulse done[owner], then return to IDLE.
- Read path:
  - R_GAP: idle 5 cycles.
  - R_LD: read_ld=1, readaddr=addr.
  - R_FILL: read_ld=0; wait for rd_buffer ≥ len_e.
  - R_STR: read_req=1 for exactly len_e cycles.
  - R_TAIL: read_req=0; one cycle for the last word.
  - FIN.
- Read data routing:
  - rd_data is the registered readdata.
  - rd_valid[owner]=1 for len_e consecutive cycles, starting one cycle after the first read_req cycle.
- Timeout:
  - A wait counter runs in W_DRN and R_FILL and clears on state entry.
  - When it reaches TIMEOUT: deassert all strobes, pulse err[owner] (no done), return to IDLE.
- Ordering:
  - Exactly one transaction is in flight at a time.
  - Address and data outputs hold their last values when idle.

## Timing
- Accept latency: req_ack appears the cycle after req_valid is seen in IDLE. A requester may drop req_valid the cycle after req_ack.
- Write latency: ack → done is 6 cycles plus the drain wait (minimum 6 with wr_buffer already 0).
- Read latency: ack → first rd_valid is 5 (gap) + 1 (ld) + fill wait + 2 cycles.
- Back-to-back: IDLE → IDLE takes at least one cycle, so a new grant can occur no earlier than the cycle after done.
- write_ld and read_ld are never high in the same cycle. No *_req strobe is ever high in the same cycle as its own *_ld.
- Simultaneous requests resolve strictly by the round-robin pointer. A requester that drops req_valid before ack is ignored.
- Reset mid-transaction aborts immediately: no done or err pulse, and all strobes go to 0 asynchronously.

## Test plan
- Reset then single write: req 1 write addr 0x00C8 data 0x000F, wr_buffer=0 → write_ld high 1 cycle with writeaddr 0x00C8, then write_req high 1 cycle with writedata 0x000F, done[1] 6 cycles after ack.
- Read burst: req 2 read addr 0x0032 len 10, rd_buffer steps 0→10 → read_req high exactly 10 cycles, rd_valid[2] high 10 cycles carrying the FIFO sequence in order, done[2] after.
- Length edges:
  - len 0 → 1 word returned.
  - len 20 → clamped to 16 read_req cycles.
- Round-robin: all 4 requesting continuously from reset → ack order 0,1,2,3,0.
- Round-robin with one requester: only req 3 → repeated acks to 3 with no stall.
- Timeout: write with wr_buffer stuck at 1 → err[owner] exactly TIMEOUT cycles after entering W_DRN, no done, next request is granted.
- Reset asserted during R_STR → read_req, rd_valid and done all 0 immediately; after release, the first grant goes to requester 0.
